// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter shared by the fetch and memory stages.
// Data accesses win over fetch; each access runs WAIT_CYCLES cycles, then a one-cycle ready.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_freeze,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_freeze,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                owner_data_r;
    logic                is_write_r;
    logic                grant_s;
    logic                grant_data_s;
    logic                last_s;
    logic                write_next_s;
    logic                mem_any_s;
    logic [31:0]         grant_addr_s;
    logic [ADDR_W-1:0]   sram_addr_r;
    logic [31:0]         sram_wdata_r;
    logic                sram_en_r;
    logic                sram_we_r;
    logic [31:0]         if_rdata_r;
    logic [31:0]         mem_rdata_r;
    logic                if_ready_r;
    logic                mem_ready_r;

    assign mem_any_s = mem_rd_req | mem_wr_req;

    // Arbitration and next-state decode
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        grant_data_s = 1'b0;
        last_s       = (cnt_r == CNT_W'(WAIT_CYCLES - 1));
        case (state_r)
            IDLE: begin
                if (mem_any_s) begin
                    grant_s      = 1'b1;
                    grant_data_s = 1'b1;
                    state_next_s = ACCESS;
                end else if (if_req) begin
                    grant_s      = 1'b1;
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (last_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Address source and write qualifier for the access about to start
    always_comb begin
        grant_addr_s = if_addr;
        write_next_s = is_write_r;
        if (grant_data_s) begin
            grant_addr_s = mem_addr;
        end else begin
            grant_addr_s = if_addr;
        end
        if (grant_s) begin
            write_next_s = grant_data_s & mem_wr_req;
        end else begin
            write_next_s = is_write_r;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Access sequencing, SRAM drive and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r        <= {CNT_W{1'b0}};
            owner_data_r <= 1'b0;
            is_write_r   <= 1'b0;
            sram_addr_r  <= {ADDR_W{1'b0}};
            sram_wdata_r <= 32'h0000_0000;
            sram_en_r    <= 1'b0;
            sram_we_r    <= 1'b0;
            if_rdata_r   <= 32'h0000_0000;
            mem_rdata_r  <= 32'h0000_0000;
            if_ready_r   <= 1'b0;
            mem_ready_r  <= 1'b0;
        end else begin
            if (grant_s) begin
                owner_data_r <= grant_data_s;
                is_write_r   <= write_next_s;
                sram_addr_r  <= grant_addr_s[ADDR_W+1:2];
                sram_wdata_r <= mem_wdata;
                cnt_r        <= {CNT_W{1'b0}};
            end else if (state_r == ACCESS) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            sram_en_r   <= (state_next_s == ACCESS);
            sram_we_r   <= (state_next_s == ACCESS) & write_next_s;
            if_ready_r  <= (state_r == ACCESS) & last_s & ~owner_data_r;
            mem_ready_r <= (state_r == ACCESS) & last_s & owner_data_r;
            // sram_rdata is only valid in the final access cycle
            if ((state_r == ACCESS) && last_s && !is_write_r) begin
                if (owner_data_r) begin
                    mem_rdata_r <= sram_rdata;
                end else begin
                    if_rdata_r <= sram_rdata;
                end
            end
        end
    end

    assign sram_en    = sram_en_r;
    assign sram_we    = sram_we_r;
    assign sram_addr  = sram_addr_r;
    assign sram_wdata = sram_wdata_r;
    assign if_rdata   = if_rdata_r;
    assign mem_rdata  = mem_rdata_r;
    assign if_ready   = if_ready_r;
    assign mem_ready  = mem_ready_r;

    // Freeze releases in the ready cycle so the stage advances with the data
    assign if_freeze  = if_req & ~if_ready_r;
    assign mem_freeze = mem_any_s & ~mem_ready_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256-word SRAM.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_freeze;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_freeze;
    logic        sram_en;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] sram_mem [0:255];
    int          checks;
    int          errors;

    mem_port_arbiter #(.WAIT_CYCLES(2), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .if_freeze  (if_freeze),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_freeze (mem_freeze),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read, write on the clock edge
    assign sram_rdata = sram_mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (sram_en && sram_we) sram_mem[sram_addr[7:0]] <= sram_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [31:0] exp_data [0:2];
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0;
        sram_mem[0]    = 32'h1111_1111;
        sram_mem[1]    = 32'h2222_2222;
        sram_mem[2]    = 32'h3333_3333;
        sram_mem[4]    = 32'hE3A0_1005;
        sram_mem[8'h80] = 32'hAAAA_5555;
        exp_data[0] = 32'h1111_1111;
        exp_data[1] = 32'h2222_2222;
        exp_data[2] = 32'h3333_3333;

        // Reset values
        #2;
        check_eq("rst_sram_en", {31'h0, sram_en}, 32'h0);
        check_eq("rst_sram_addr", {16'h0, sram_addr}, 32'h0);
        check_eq("rst_if_rdata", if_rdata, 32'h0);
        check_eq("rst_ready", {30'h0, if_ready, mem_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Reset asserted in the second access cycle of a fetch
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        tick();
        check_eq("t4_en_c1", {31'h0, sram_en}, 32'h1);
        tick();
        rst = 1'b0;
        #1;
        check_eq("t4_en_async", {31'h0, sram_en}, 32'h0);
        @(negedge clk);
        check_eq("t4_no_ready", {31'h0, if_ready}, 32'h0);
        check_eq("t4_rdata", if_rdata, 32'h0);
        rst = 1'b1;

        // Restarted fetch of word 4
        #1;
        check_eq("t1_freeze_t0", {31'h0, if_freeze}, 32'h1);
        @(negedge clk);
        check_eq("t1_en_t1", {31'h0, sram_en}, 32'h1);
        check_eq("t1_addr_t1", {16'h0, sram_addr}, 32'h4);
        check_eq("t1_we_t1", {31'h0, sram_we}, 32'h0);
        check_eq("t1_freeze_t1", {31'h0, if_freeze}, 32'h1);
        tick();
        check_eq("t1_en_t2", {31'h0, sram_en}, 32'h1);
        check_eq("t1_ready_t2", {31'h0, if_ready}, 32'h0);
        tick();
        check_eq("t1_ready_t3", {31'h0, if_ready}, 32'h1);
        check_eq("t1_rdata", if_rdata, 32'hE3A0_1005);
        check_eq("t1_en_t3", {31'h0, sram_en}, 32'h0);
        check_eq("t1_freeze_t3", {31'h0, if_freeze}, 32'h0);
        if_req = 1'b0;
        tick();
        check_eq("t1_ready_t4", {31'h0, if_ready}, 32'h0);

        // Data write to 0x104
        mem_wr_req = 1'b1;
        mem_addr   = 32'h0000_0104;
        mem_wdata  = 32'hDEAD_BEEF;
        tick();
        check_eq("t2_we_t1", {31'h0, sram_we}, 32'h1);
        check_eq("t2_addr", {16'h0, sram_addr}, 32'h41);
        check_eq("t2_wdata", sram_wdata, 32'hDEAD_BEEF);
        tick();
        check_eq("t2_we_t2", {31'h0, sram_we}, 32'h1);
        check_eq("t2_freeze", {31'h0, mem_freeze}, 32'h1);
        tick();
        check_eq("t2_ready", {31'h0, mem_ready}, 32'h1);
        check_eq("t2_rdata_hold", mem_rdata, 32'h0);
        check_eq("t2_we_off", {31'h0, sram_we}, 32'h0);
        mem_wr_req = 1'b0;
        tick();
        check_eq("t2_ready_once", {31'h0, mem_ready}, 32'h0);
        check_eq("t2_sram_word", sram_mem[8'h41], 32'hDEAD_BEEF);
        mem_rd_req = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t2_rd_ready", {31'h0, mem_ready}, 32'h1);
        check_eq("t2_rd_data", mem_rdata, 32'hDEAD_BEEF);
        mem_rd_req = 1'b0;
        tick();

        // Back-to-back fetches, ready pulses four cycles apart
        if_req  = 1'b1;
        if_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!if_ready && n < 20);
            check_eq($sformatf("t5_gap%0d", k), n, (k == 0) ? 32'd3 : 32'd4);
            check_eq($sformatf("t5_data%0d", k), if_rdata, exp_data[k]);
            if_addr = 32'(k + 1) * 32'd4;
        end
        if_req = 1'b0;
        tick();

        // Simultaneous fetch and data read; data wins
        if_req     = 1'b1;
        if_addr    = 32'h0000_0008;
        mem_rd_req = 1'b1;
        mem_addr   = 32'h0000_0200;
        #1;
        check_eq("t3_ifz_t0", {31'h0, if_freeze}, 32'h1);
        check_eq("t3_mfz_t0", {31'h0, mem_freeze}, 32'h1);
        @(negedge clk);
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) tick();
            check_eq($sformatf("t3_mrdy%0d", i), {31'h0, mem_ready}, (i == 3) ? 32'h1 : 32'h0);
            if (i == 3) begin
                check_eq("t3_mdata", mem_rdata, 32'hAAAA_5555);
                mem_rd_req = 1'b0;
            end
            if (i < 7) begin
                check_eq($sformatf("t3_ifz%0d", i), {31'h0, if_freeze}, 32'h1);
            end else begin
                check_eq("t3_if_ready", {31'h0, if_ready}, 32'h1);
                check_eq("t3_if_data", if_rdata, 32'h3333_3333);
            end
        end
        if_req = 1'b0;
        tick();

        // Read and write together behave as a write
        mem_rd_req = 1'b1;
        mem_wr_req = 1'b1;
        mem_addr   = 32'h0000_0300;
        mem_wdata  = 32'h1234_5678;
        tick();
        check_eq("t6_we", {31'h0, sram_we}, 32'h1);
        tick();
        tick();
        check_eq("t6_ready", {31'h0, mem_ready}, 32'h1);
        check_eq("t6_rdata_hold", mem_rdata, 32'hAAAA_5555);
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        tick();
        check_eq("t6_sram_word", sram_mem[8'hC0], 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency instruction/data SRAM between the fetch stage and the memory stage.
- Grants one access at a time and sequences the SRAM through a multi-cycle access.
- Returns read data to the owning requester with a one-cycle ready pulse.
- Produces per-requester freeze signals that the pipeline uses to hold the IF stage and the MEM stage while an access is pending.

Parameters:
- WAIT_CYCLES, 2: SRAM access latency in cycles. Must be ≥1.
- ADDR_W, 16: SRAM word-address width.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- if_req, input, 1: fetch request (read only).
- if_addr, input, 32: fetch byte address.
- if_rdata, output, 32: fetched instruction.
- if_ready, output, 1: one-cycle pulse; if_rdata valid.
- if_freeze, output, 1: fetch pending, hold IF.
- mem_rd_req, input, 1: data read request.
- mem_wr_req, input, 1: data write request.
- mem_addr, input, 32: data byte address.
- mem_wdata, input, 32: write data.
- mem_rdata, output, 32: read data.
- mem_ready, output, 1: one-cycle pulse; access complete.
- mem_freeze, output, 1: data access pending, hold MEM.
- sram_en, output, 1: SRAM access enable.
- sram_we, output, 1: SRAM write enable.
- sram_addr, output, ADDR_W: SRAM word address.
- sram_wdata, output, 32: SRAM write data.
- sram_rdata, input, 32: SRAM read data, valid in the last ACCESS cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, cnt=0, owner=fetch.
  - All outputs 0: both rdata registers, both ready, sram_en, sram_we, sram_addr, sram_wdata.
  - freeze outputs follow their formula (req & ~ready), so they are not forced low.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If mem_rd_req|mem_wr_req: grant data, owner=data.
  - Else if if_req: grant fetch, owner=fetch.
  - Else stay in IDLE.
  - On grant, latch:
    - sram_addr = addr[ADDR_W+1:2] (byte address to word address; upper bits dropped);
    - sram_wdata = mem_wdata;
    - is_write = mem_wr_req & data-granted.
  - Then go to ACCESS, cnt=0.
- ACCESS:
  - sram_en=1; sram_we=is_write.
  - Address and data held stable for the whole access.
  - cnt increments each cycle.
  - When cnt==WAIT_CYCLES-1:
    - if read, capture sram_rdata into the owner's rdata register;
    - go to RESP.
- RESP:
  - sram_en=0, sram_we=0.
  - Owner's ready=1 for exactly this cycle.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle t, ACCESS in cycles t+1..t+WAIT_CYCLES, ready high in cycle t+WAIT_CYCLES+1.
- Minimum spacing between grants: WAIT_CYCLES+2 cycles.
- Freeze outputs (combinational):
  - if_freeze = if_req & ~if_ready;
  - mem_freeze = (mem_rd_req|mem_wr_req) & ~mem_ready.
- Priority: data beats fetch when both are pending in IDLE. Fetch cannot starve, because MEM issues at most one access per instruction and then deasserts.
- Requester contract: hold req/addr/wdata stable until ready. Deassert, or present a new request, in the cycle after ready.
- Requests arriving during ACCESS/RESP are not sampled; they are evaluated on the next IDLE.
- Requester drops req mid-access: the access completes and ready still pulses. For reads, rdata updates.
- mem_rd_req and mem_wr_req both high: treated as a write, and rdata is not updated.
- Write completion: mem_ready pulses; mem_rdata is unchanged.
- rdata registers hold their last captured value until the same owner's next read completes.
- Reset mid-ACCESS:
  - immediate return to IDLE; sram_en and sram_we drop asynchronously;
  - no ready pulse; no rdata update.
  - After rst is released, pending requests are re-arbitrated from IDLE.

Test Plan:
1. Fetch read, WAIT_CYCLES=2, if_addr=0x0000_0010, SRAM word 4 = 0xE3A0_1005:
   - sram_en high for 2 cycles with sram_addr=4;
   - if_ready pulses 3 cycles after the request with if_rdata=0xE3A0_1005;
   - if_freeze high until that cycle.
2. Data write, mem_addr=0x0000_0104, mem_wdata=0xDEAD_BEEF:
   - sram_we=1 and sram_addr=0x41 for 2 cycles;
   - mem_ready pulses once; mem_rdata unchanged;
   - a subsequent read of 0x104 returns 0xDEAD_BEEF.
3. if_req and mem_rd_req rise in the same cycle:
   - data is served first (mem_ready at t+3);
   - fetch is granted in the next IDLE (if_ready at t+7);
   - if_freeze stays high throughout t..t+6.
4. rst driven low during the 2nd ACCESS cycle:
   - sram_en drops immediately; no ready pulse; if_rdata stays 0.
   - After release with if_req still high, a full access restarts.
5. Back-to-back fetches at addresses 0x0, 0x4, 0x8: ready pulses are spaced exactly 4 cycles apart (WAIT_CYCLES=2), with correct data each time.
6. mem_rd_req and mem_wr_req asserted together: a write occurs and mem_rdata is unchanged.
